// File: rtl/crc16_32_engine.sv
// rtl/crc16_32_engine.sv - memory-mapped CRC-16/X.25 and CRC-32 FCS generator/checker
// Optional feature macro: CRC32_EN (undefined builds a 16-bit CRC-16-only engine).
// A write strobe rising edge is captured into evt_q/addr_q/data_q and acted on at the
// following clk edge. A word write folds its low byte first, holds the high byte in
// pend_q and folds it one clk later while busy_q is high.
module crc16_32_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic [2:0]  ioaddr,
  input  logic [15:0] din,
  input  logic        iowr,
  input  logic        iord,
  output logic [15:0] dout
);

`ifdef CRC32_EN
  localparam int CW = 32;
`else
  localparam int CW = 16;
`endif

  logic          wr;
  logic          wr_q;
  logic          wr_evt;
  logic          accept;
  logic          evt_q;
  logic [2:0]    addr_q;
  logic [15:0]   data_q;
  logic [CW-1:0] crc_q;
  logic [CW-1:0] crc_fold_d;
  logic [CW-1:0] fcs;
  logic          busy_q;
  logic [7:0]    pend_q;
  logic [7:0]    fold_byte;
  logic          mode;
  logic [15:0]   rdata;

`ifdef CRC32_EN
  logic          mode_q;

  // Eight serial LSB-first steps; CRC-16 mode works on the low half and holds the upper half.
  function automatic logic [31:0] crc_fold(input logic [31:0] c_in, input logic [7:0] d,
                                           input logic m32);
    logic [31:0] c;
    logic [15:0] c16;
    c   = c_in;
    c16 = c_in[15:0];
    for (int i = 0; i < 8; i++) begin
      c   = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0000_0000);
      c16 = (c16 >> 1) ^ ((c16[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    end
    if (!m32) begin
      c = {c_in[31:16], c16};
    end
    return c;
  endfunction

  assign mode = mode_q;
`else
  // Eight serial LSB-first steps of the CRC-16/X.25 polynomial.
  function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c16;
    c16 = c_in;
    for (int i = 0; i < 8; i++) begin
      c16 = (c16 >> 1) ^ ((c16[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    end
    return c16;
  endfunction

  assign mode = 1'b0;
`endif

  assign wr     = iocs & iowr;
  assign wr_evt = wr & ~wr_q;
  // Addresses 4-7 are dropped here; byte/word writes are dropped while the high byte is pending,
  // but preset/control writes always get through so they can override a pending byte.
  assign accept = wr_evt & ~ioaddr[2] & (~busy_q | ioaddr[1]);

  // Byte to fold this cycle and the resulting register value.
  always_comb begin
    fold_byte = busy_q ? pend_q : data_q[7:0];
`ifdef CRC32_EN
    crc_fold_d = crc_fold(crc_q, fold_byte, mode_q);
`else
    crc_fold_d = crc_fold(crc_q, fold_byte);
`endif
  end

  // Write-edge capture, preset/control handling and byte/word folding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= 1'b0;
      evt_q  <= 1'b0;
      addr_q <= 3'd0;
      data_q <= 16'h0000;
      crc_q  <= '1;
      busy_q <= 1'b0;
      pend_q <= 8'h00;
`ifdef CRC32_EN
      mode_q <= 1'b0;
`endif
    end else begin
      wr_q  <= wr;
      evt_q <= accept;
      if (accept) begin
        addr_q <= ioaddr;
        data_q <= din;
      end
      if (evt_q && addr_q[1]) begin
        // Preset (addr 3) or control (addr 2): wins over any pending high byte.
        crc_q  <= '1;
        busy_q <= 1'b0;
`ifdef CRC32_EN
        if (!addr_q[0]) begin
          mode_q <= data_q[0];
        end
`endif
      end else if (busy_q) begin
        crc_q  <= crc_fold_d;
        busy_q <= 1'b0;
      end else if (evt_q) begin
        crc_q <= crc_fold_d;
        if (addr_q[0]) begin
          pend_q <= data_q[15:8];
          busy_q <= 1'b1;
        end
      end
    end
  end

  // Combinational read mux; reads have no side effects.
  always_comb begin
    fcs   = ~crc_q;
    rdata = 16'h0000;
    case (ioaddr)
      3'd0: rdata = fcs[15:0];
`ifdef CRC32_EN
      3'd1: rdata = mode_q ? fcs[31:16] : 16'h0000;
`else
      3'd1: rdata = 16'h0000;
`endif
      3'd2: rdata = {13'b0, busy_q, 1'b0, mode};
      3'd3: rdata = crc_q[15:0];
      default: rdata = 16'h0000;
    endcase
    dout = (iocs & iord) ? rdata : 16'h0000;
  end

endmodule

// File: tb/tb_crc16_32_engine.sv
// tb/tb_crc16_32_engine.sv - table-driven bench for crc16_32_engine
module tb_crc16_32_engine;

`ifdef CRC32_EN
  localparam bit HAS32 = 1'b1;
`else
  localparam bit HAS32 = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        iocs;
  logic [2:0]  ioaddr;
  logic [15:0] din;
  logic        iowr;
  logic        iord;
  logic [15:0] dout;

  int total;
  int bad;

  crc16_32_engine dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .ioaddr (ioaddr),
    .din    (din),
    .iowr   (iowr),
    .iord   (iord),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add_w(input logic [2:0] a, input logic [15:0] d);
    vec_t v;
    v.rd = 1'b0; v.addr = a; v.data = d; v.exp = 16'h0000; v.tag = "wr";
    vecs.push_back(v);
  endtask

  task automatic add_r(input logic [2:0] a, input logic [15:0] e, input string t);
    vec_t v;
    v.rd = 1'b1; v.addr = a; v.data = 16'h0000; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic check(input logic [15:0] got, input logic [15:0] want, input string t);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", t, got, want);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input int hold, input int idle);
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = a; din = d;
    repeat (hold) @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] want, input string t);
    @(negedge clk);
    iocs = 1'b1; iord = 1'b1; ioaddr = a;
    #1;
    check(dout, want, t);
    iocs = 1'b0; iord = 1'b0;
  endtask

  function automatic logic [31:0] model_byte(input logic [31:0] c, input logic [7:0] d, input bit m32);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (m32) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
      else     r[15:0] = (r[15:0] >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  initial begin
    logic [31:0] mc;
    logic [31:0] mf;
    bit          m_eff;
    total = 0; bad = 0;
    rst = 1'b0; iocs = 1'b0; ioaddr = 3'd0; din = 16'h0000; iowr = 1'b0; iord = 1'b0;

    // reset state
    add_r(3'd0, 16'h0000, "rst_fcs");
    add_r(3'd2, 16'h0000, "rst_ctrl");
    add_r(3'd1, 16'h0000, "rst_fcs_hi");
    add_r(3'd3, 16'hFFFF, "rst_raw");
    // CRC-16 check string and residue
    add_w(3'd2, 16'h0000);
    for (int b = 8'h31; b <= 8'h39; b++) add_w(3'd0, 16'(b));
    add_r(3'd0, 16'h906E, "chk16");
    add_r(3'd1, 16'h0000, "chk16_hi");
    add_r(3'd3, 16'h6F91, "chk16_raw");
    add_w(3'd0, 16'h006E);
    add_w(3'd0, 16'h0090);
    add_r(3'd3, 16'hF0B8, "res16");
    // CRC-32 check string (falls back to CRC-16 when only CRC-16 is built)
    add_w(3'd2, 16'h0001);
    add_r(3'd2, HAS32 ? 16'h0001 : 16'h0000, "ctrl32");
    for (int b = 8'h31; b <= 8'h39; b++) add_w(3'd0, 16'(b));
    add_r(3'd0, HAS32 ? 16'h3926 : 16'h906E, "chk32_lo");
    add_r(3'd1, HAS32 ? 16'hCBF4 : 16'h0000, "chk32_hi");
`ifdef CRC32_EN
    add_w(3'd0, 16'h0026);
    add_w(3'd0, 16'h0039);
    add_w(3'd0, 16'h00F4);
    add_w(3'd0, 16'h00CB);
    add_r(3'd0, 16'hDF1C, "res32_lo");
    add_r(3'd1, 16'h2144, "res32_hi");
    add_r(3'd3, 16'h20E3, "res32_raw");
`endif
    add_w(3'd2, 16'h0000);
    add_r(3'd2, 16'h0000, "ctrl16");
    add_w(3'd6, 16'h0001);
    add_r(3'd3, 16'hFFFF, "ign_addr6");

    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      if (vecs[k].rd) do_read(vecs[k].addr, vecs[k].exp, vecs[k].tag);
      else            do_write(vecs[k].addr, vecs[k].data, 2, 3);
    end

    // word path equivalence in both modes
    for (int m = 0; m < 2; m++) begin
      m_eff = (m == 1) && HAS32;
      mc = 32'hFFFF_FFFF;
      for (int n = 0; n < 16; n++) mc = model_byte(mc, 8'h37, m_eff);
      mf = ~mc;
      do_write(3'd2, 16'(m), 1, 3);
      do_write(3'd3, 16'h0000, 1, 3);
      for (int n = 0; n < 16; n++) do_write(3'd0, 16'h0037, 2, 3);
      do_read(3'd0, mf[15:0], "byte37_lo");
      do_read(3'd1, m_eff ? mf[31:16] : 16'h0000, "byte37_hi");
      do_write(3'd3, 16'h0000, 1, 3);
      for (int n = 0; n < 8; n++) do_write(3'd1, 16'h3737, 1, 3);
      do_read(3'd0, mf[15:0], "word37_lo");
      do_read(3'd1, m_eff ? mf[31:16] : 16'h0000, "word37_hi");
    end
    do_write(3'd2, 16'h0000, 1, 3);

    // busy is high only for the cycle between the two byte folds
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'h3737;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iord = 1'b1; ioaddr = 3'd2; #1;
    check(dout, 16'h0004, "busy_set");
    iocs = 1'b0; iord = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iord = 1'b1; ioaddr = 3'd2; #1;
    check(dout, 16'h0000, "busy_clr");
    iocs = 1'b0; iord = 1'b0;
    repeat (3) @(negedge clk);

    // word write then preset on the next write edge: preset wins
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'h1234;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd3; din = 16'h0000;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    repeat (3) @(negedge clk);
    do_read(3'd3, 16'hFFFF, "preset_wins_raw");
    do_read(3'd2, 16'h0000, "preset_wins_busy");

    // word write then a byte write on the next write edge: byte ignored
    mc = 32'hFFFF_FFFF;
    mc = model_byte(mc, 8'h37, 1'b0);
    mc = model_byte(mc, 8'h37, 1'b0);
    mf = ~mc;
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'h3737;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd0; din = 16'h0055;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    repeat (3) @(negedge clk);
    do_read(3'd0, mf[15:0], "busy_ignore");

    // reset mid-word discards the pending byte
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'hA5C3;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_read(3'd3, 16'hFFFF, "rst_mid_raw");
    do_read(3'd2, 16'h0000, "rst_mid_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
